// File: rtl/junction_phase_sequencer.sv
// Highway / country-road junction phase scheduler: one shared countdown timer
// walks both light groups through green, yellow and all-red clearance phases.
module junction_phase_sequencer #(
  parameter int TW     = 6,
  parameter int HG_MIN = 20,
  parameter int RG_MAX = 15,
  parameter int YEL    = 3,
  parameter int ALLRED = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          car,
  input  logic          hold,
  output logic [2:0]    light_h,
  output logic [2:0]    light_r,
  output logic [TW-1:0] remaining,
  output logic [2:0]    phase,
  output logic          phase_change
);

  typedef enum logic [2:0] {
    H_GREEN   = 3'd0,
    H_YELLOW  = 3'd1,
    ALLRED_HR = 3'd2,
    R_GREEN   = 3'd3,
    R_YELLOW  = 3'd4,
    ALLRED_RH = 3'd5
  } state_e;

  localparam logic [2:0] GRN = 3'b100;
  localparam logic [2:0] YLW = 3'b010;
  localparam logic [2:0] RED = 3'b001;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          car_pend_q, car_pend_d;
  logic          chg_q;
  logic          adv;

  assign adv = tick & ~hold;

  function automatic logic [TW-1:0] entry_dur(input state_e s);
    case (s)
      H_GREEN:             entry_dur = TW'(HG_MIN);
      H_YELLOW, R_YELLOW:  entry_dur = TW'(YEL);
      R_GREEN:             entry_dur = TW'(RG_MAX);
      default:             entry_dur = TW'(ALLRED);
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= H_GREEN;
      timer_q    <= TW'(HG_MIN);
      car_pend_q <= 1'b0;
      chg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      car_pend_q <= car_pend_d;
      chg_q      <= (state_d != state_q);
    end
  end

  // Timed phases leave on the tick that would take the timer from 1 to 0,
  // so each lasts exactly its duration; only H_GREEN can rest at 0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      H_GREEN:   if (car_pend_q && (timer_q == '0 || (timer_q == TW'(1) && adv)))
                   state_d = H_YELLOW;
      H_YELLOW:  if (adv && timer_q == TW'(1)) state_d = ALLRED_HR;
      ALLRED_HR: if (adv && timer_q == TW'(1)) state_d = R_GREEN;
      R_GREEN:   if (adv && (timer_q == TW'(1) || !car)) state_d = R_YELLOW;
      R_YELLOW:  if (adv && timer_q == TW'(1)) state_d = ALLRED_RH;
      ALLRED_RH: if (adv && timer_q == TW'(1)) state_d = H_GREEN;
      default:   state_d = H_GREEN;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q)
      timer_d = entry_dur(state_d);
    else if (adv && timer_q != '0)
      timer_d = timer_q - TW'(1);
  end

  // Request is consumed by serving the country road; cars seen elsewhere latch.
  assign car_pend_d = (state_q == R_GREEN) ? 1'b0 : (car_pend_q | car);

  always_comb begin
    light_h = RED;
    light_r = RED;
    case (state_q)
      H_GREEN:  light_h = GRN;
      H_YELLOW: light_h = YLW;
      R_GREEN:  light_r = GRN;
      R_YELLOW: light_r = YLW;
      default: ;
    endcase
  end

  assign phase        = state_q;
  assign remaining    = timer_q;
  assign phase_change = chg_q;

endmodule
